// File: rtl/button_event_decoder.sv
// Front-panel gesture classifier: turns a debounced button level into press/release
// strobes and short-click, double-click and long-press events timed by a prescaled tick.
module button_event_decoder #(
  parameter int TICK_DIVISOR       = 125000,
  parameter int LONG_PRESS_TICKS   = 1000,
  parameter int DOUBLE_CLICK_TICKS = 300
) (
  input  logic       clk,
  input  logic       resetActiveLow,
  input  logic       buttonPressed,
  output logic       pressStrobe,
  output logic       releaseStrobe,
  output logic       shortClick,
  output logic       doubleClick,
  output logic       longPress,
  output logic [7:0] eventCount
);

  localparam int MAX_TICKS = (LONG_PRESS_TICKS > DOUBLE_CLICK_TICKS) ?
                             LONG_PRESS_TICKS : DOUBLE_CLICK_TICKS;
  localparam int TW = $clog2(MAX_TICKS + 1);
  localparam int PW = $clog2(TICK_DIVISOR);

  localparam logic [TW-1:0] LONG_T = TW'(LONG_PRESS_TICKS);
  localparam logic [TW-1:0] DBL_T  = TW'(DOUBLE_CLICK_TICKS);
  localparam logic [TW-1:0] MAX_T  = TW'(MAX_TICKS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIVISOR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESSED,
    S_WAIT_SECOND,
    S_SECOND_PRESSED,
    S_LONG_HELD
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            prev_pressed_q, prev_pressed_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            short_q, short_d;
  logic            double_q, double_d;
  logic            long_q, long_d;
  logic [7:0]      count_q, count_d;

  logic            rise, fall, tick, any_event;

  // Edge detection and free-running tick prescaler
  always_comb begin
    prev_pressed_d = buttonPressed;
    rise           = buttonPressed & ~prev_pressed_q;
    fall           = ~buttonPressed & prev_pressed_q;
    tick           = (presc_q == PRESC_LAST);
    presc_d        = tick ? '0 : presc_q + PW'(1);
    press_d        = rise;
    release_d      = fall;
  end

  // Gesture FSM: an edge always takes priority over a timeout in the same cycle
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_PRESSED;
      end
      S_PRESSED: begin
        if (fall) begin
          state_d = S_WAIT_SECOND;
        end else if (timer_q == LONG_T) begin
          long_d  = 1'b1;
          state_d = S_LONG_HELD;
        end
      end
      S_WAIT_SECOND: begin
        if (rise) begin
          state_d = S_SECOND_PRESSED;
        end else if (timer_q == DBL_T) begin
          short_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SECOND_PRESSED: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = S_IDLE;
        end else if (timer_q == LONG_T) begin
          // the pending first click is dropped in favour of the long press
          long_d  = 1'b1;
          state_d = S_LONG_HELD;
        end
      end
      S_LONG_HELD: begin
        if (fall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tick timer restarts on every state change and saturates at the longest limit
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick && (timer_q != MAX_T)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_comb begin
    any_event = short_d | double_d | long_d;
    count_d   = count_q + {7'd0, any_event};
  end

  always_ff @(posedge clk or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      state_q        <= S_IDLE;
      presc_q        <= '0;
      timer_q        <= '0;
      prev_pressed_q <= 1'b0;
      press_q        <= 1'b0;
      release_q      <= 1'b0;
      short_q        <= 1'b0;
      double_q       <= 1'b0;
      long_q         <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      timer_q        <= timer_d;
      prev_pressed_q <= prev_pressed_d;
      press_q        <= press_d;
      release_q      <= release_d;
      short_q        <= short_d;
      double_q       <= double_d;
      long_q         <= long_d;
      count_q        <= count_d;
    end
  end

  assign pressStrobe   = press_q;
  assign releaseStrobe = release_q;
  assign shortClick    = short_q;
  assign doubleClick   = double_q;
  assign longPress     = long_q;
  assign eventCount    = count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: expected strobes and events are queued
// as gestures are driven and matched against the DUT's one-cycle pulses.
module tb_button_event_decoder;

  localparam logic [2:0] K_SHORT = 3'b001;
  localparam logic [2:0] K_DBL   = 3'b010;
  localparam logic [2:0] K_LONG  = 3'b100;

  logic       clk = 1'b0;
  logic       resetActiveLow;
  logic       buttonPressed;
  logic       pressStrobe, releaseStrobe, shortClick, doubleClick, longPress;
  logic [7:0] eventCount;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] cnt;
    int         lo;
    int         hi;
  } ev_t;

  typedef struct {
    logic is_press;
    int   at;
  } st_t;

  ev_t  evq[$];
  st_t  sq[$];
  int   cyc = 0;
  int   c0 = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [7:0] exp_count = 8'd0;

  button_event_decoder #(
    .TICK_DIVISOR      (4),
    .LONG_PRESS_TICKS  (8),
    .DOUBLE_CLICK_TICKS(3)
  ) dut (
    .clk           (clk),
    .resetActiveLow(resetActiveLow),
    .buttonPressed (buttonPressed),
    .pressStrobe   (pressStrobe),
    .releaseStrobe (releaseStrobe),
    .shortClick    (shortClick),
    .doubleClick   (doubleClick),
    .longPress     (longPress),
    .eventCount    (eventCount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input logic v);
    st_t s;
    if (buttonPressed !== v) begin
      s.is_press = v;
      s.at       = cyc + 1;
      sq.push_back(s);
    end
    buttonPressed = v;
  endtask

  task automatic push_evt(input logic [2:0] k, input int lo, input int hi);
    ev_t e;
    exp_count = exp_count + 8'd1;
    e.kind = k;
    e.cnt  = exp_count;
    e.lo   = lo;
    e.hi   = hi;
    evq.push_back(e);
  endtask

  task automatic do_reset();
    resetActiveLow = 1'b0;
    repeat (3) @(negedge clk);
    #1 resetActiveLow = 1'b1;
    c0        = cyc;
    exp_count = 8'd0;
  endtask

  // Release at R: WAIT_SECOND starts at edge R+1, the third tick lands 10..13 edges later.
  task automatic short_click();
    int r;
    set_btn(1'b1);
    idle(8);
    r = cyc;
    set_btn(1'b0);
    push_evt(K_SHORT, r + 11, r + 14);
    idle(24);
  endtask

  // Output monitor: every high output cycle must match the head of its queue.
  always @(negedge clk) begin : mon
    st_t s;
    ev_t e;
    logic [2:0] k;
    if (resetActiveLow === 1'b1) begin
      if (pressStrobe || releaseStrobe) begin
        if (sq.size() == 0) chk("strobe_unexpected", {31'd0, pressStrobe | releaseStrobe}, 0);
        else begin
          s = sq.pop_front();
          chk("strobe_kind", {31'd0, pressStrobe}, {31'd0, s.is_press});
          chk("strobe_cycle", cyc, s.at);
        end
      end
      k = {longPress, doubleClick, shortClick};
      if (k != 3'b000) begin
        if (evq.size() == 0) chk("event_unexpected", {29'd0, k}, 0);
        else begin
          e = evq.pop_front();
          chk("event_kind", {29'd0, k}, {29'd0, e.kind});
          chk("event_count", {24'd0, eventCount}, {24'd0, e.cnt});
          chk("event_in_window", {31'd0, (cyc >= e.lo) && (cyc <= e.hi)}, 1);
        end
      end
    end
  end

  initial begin
    int p, r, s, t3, e, n;
    resetActiveLow = 1'b0;
    buttonPressed  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_press",   {31'd0, pressStrobe}, 0);
    chk("rst_release", {31'd0, releaseStrobe}, 0);
    chk("rst_short",   {31'd0, shortClick}, 0);
    chk("rst_double",  {31'd0, doubleClick}, 0);
    chk("rst_long",    {31'd0, longPress}, 0);
    chk("rst_count",   {24'd0, eventCount}, 0);
    #1 resetActiveLow = 1'b1;
    c0 = cyc;
    idle(4);

    // 1: 5-tick press, release, single click confirmed after the double-click window
    set_btn(1'b1);
    idle(20);
    r = cyc;
    set_btn(1'b0);
    push_evt(K_SHORT, r + 11, r + 14);
    idle(40);

    // 2: double click
    set_btn(1'b1); idle(8);
    set_btn(1'b0); idle(4);
    set_btn(1'b1); idle(8);
    r = cyc;
    set_btn(1'b0);
    push_evt(K_DBL, r + 1, r + 1);
    idle(40);

    // 3: long hold; no click on the release
    p = cyc;
    set_btn(1'b1);
    push_evt(K_LONG, p + 31, p + 34);
    idle(80);
    set_btn(1'b0);
    idle(40);

    // 4: click followed by a held second press -> long press only
    set_btn(1'b1); idle(8);
    set_btn(1'b0); idle(4);
    s = cyc;
    set_btn(1'b1);
    push_evt(K_LONG, s + 31, s + 34);
    idle(48);
    set_btn(1'b0);
    idle(40);
    chk("count_after_gestures", {24'd0, eventCount}, {24'd0, exp_count});

    // 5: reset while PRESSED, button held through reset release
    set_btn(1'b1);
    @(negedge clk);
    #2 resetActiveLow = 1'b0;
    #1;
    chk("async_rst_press", {31'd0, pressStrobe}, 0);
    chk("async_rst_count", {24'd0, eventCount}, 0);
    repeat (3) @(negedge clk);
    #1 resetActiveLow = 1'b1;
    c0        = cyc;
    exp_count = 8'd0;
    begin
      st_t st;
      st.is_press = 1'b1;
      st.at       = cyc + 1;
      sq.push_back(st);
    end
    idle(8);
    r = cyc;
    set_btn(1'b0);
    push_evt(K_SHORT, r + 11, r + 14);
    idle(30);

    // 6: 256 clicks wrap the counter
    do_reset();
    idle(4);
    for (int i = 0; i < 256; i++) short_click();
    chk("count_wrap", {24'd0, eventCount}, {24'd0, exp_count});

    // 6b: rise exactly on the WAIT_SECOND expiry cycle wins over the timeout
    set_btn(1'b1);
    idle(8);
    r = cyc;
    set_btn(1'b0);
    e = r + 2;
    n = 0;
    t3 = 0;
    while (n < 3) begin
      if (((e - c0) % 4) == 0) begin
        n++;
        if (n == 3) t3 = e;
      end
      e++;
    end
    while (cyc < t3) @(negedge clk);
    set_btn(1'b1);
    idle(8);
    r = cyc;
    set_btn(1'b0);
    push_evt(K_DBL, r + 1, r + 1);
    idle(40);

    chk("final_count", {24'd0, eventCount}, {24'd0, exp_count});
    chk("events_outstanding", evq.size(), 0);
    chk("strobes_outstanding", sq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
